mips_inst_injector: RTL and testbench

- Parametrised external-instruction feeder for the MIPS multicycle core; drives the core's extInst / extInst_en pins.
- Replaces the fixed single-word extInst drive with a DEPTH-entry instruction buffer, loaded through a valid/ready port and issued one word per fetch.
- Two issue modes: one-shot (program runs once, then NOPs) and loop (program repeats).
- Sits between the stimulus side (bench or loader) and the core; observes the core's current_state to pace issue.

---
 rtl/mips_inst_injector.sv | 152 +++++++++++++++
 tb/tb_mips_inst_injector.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_inst_injector.sv
// External-instruction feeder for the MIPS multicycle core: a DEPTH-word program
// store loaded over valid/ready, issued one word per core fetch, once or looped.
module mips_inst_injector #(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          DEPTH       = 16,
  parameter int unsigned          STATE_W     = 4,
  parameter logic [STATE_W-1:0]   FETCH_STATE = '0,
  parameter logic [DATA_W-1:0]    NOP_INST    = '0,
  parameter int unsigned          CNT_W       = 16,
  localparam int unsigned         LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               clear,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [STATE_W-1:0] current_state,
  output logic [DATA_W-1:0]  ext_inst,
  output logic               ext_inst_en,
  output logic [LVL_W-1:0]   level,
  output logic [CNT_W-1:0]   issued_count,
  output logic [CNT_W-1:0]   loop_count,
  output logic               busy,
  output logic               done
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               mode_q;
  logic [STATE_W-1:0] prev_state_q;
  logic [DATA_W-1:0]  ext_inst_q;
  logic               ext_inst_en_q;
  logic [CNT_W-1:0]   issued_q;
  logic [CNT_W-1:0]   loop_q;

  logic               consume;
  logic               wr_fire;
  logic               at_last;
  logic [PTR_W-1:0]   rd_ptr_inc;

  // The core has taken the presented word when it leaves its fetch state.
  assign consume    = (prev_state_q == FETCH_STATE) && (current_state != FETCH_STATE);
  assign wr_ready   = (state_q == ST_IDLE) && (level_q < DEPTH_L);
  assign wr_fire    = wr_valid && wr_ready && !clear;
  assign at_last    = ({1'b0, rd_ptr_q} == (level_q - LVL_W'(1)));
  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

  // NOTE: the storage array is deliberately not reset so it can map onto RAM;
  // entries are only ever read below level, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the pre-edge values of the registers it reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      mode_q        <= 1'b0;
      prev_state_q  <= FETCH_STATE ^ STATE_W'(1);
      ext_inst_q    <= NOP_INST;
      ext_inst_en_q <= 1'b0;
      issued_q      <= '0;
      loop_q        <= '0;
    end else begin
      prev_state_q <= current_state;

      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        level_q  <= level_q + LVL_W'(1);
      end

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (clear) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            ext_inst_q    <= NOP_INST;
            ext_inst_en_q <= 1'b0;
          end else if ((state_q == ST_DONE) && abort) begin
            state_q       <= ST_IDLE;
            ext_inst_q    <= NOP_INST;
            ext_inst_en_q <= 1'b0;
          end else if (start && (level_q != '0)) begin
            state_q       <= ST_RUN;
            mode_q        <= mode;
            rd_ptr_q      <= '0;
            issued_q      <= '0;
            loop_q        <= '0;
            ext_inst_q    <= mem_q[0];
            ext_inst_en_q <= 1'b1;
          end
        end

        ST_RUN: begin
          if (abort) begin
            state_q       <= ST_IDLE;
            ext_inst_q    <= NOP_INST;
            ext_inst_en_q <= 1'b0;
          end else if (consume) begin
            issued_q <= (issued_q == '1) ? issued_q : issued_q + CNT_W'(1);
            if (!at_last) begin
              rd_ptr_q   <= rd_ptr_inc;
              ext_inst_q <= mem_q[rd_ptr_inc];
            end else if (mode_q) begin
              rd_ptr_q   <= '0;
              ext_inst_q <= mem_q[0];
              loop_q     <= (loop_q == '1) ? loop_q : loop_q + CNT_W'(1);
            end else begin
              state_q    <= ST_DONE;
              ext_inst_q <= NOP_INST;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ext_inst     = ext_inst_q;
  assign ext_inst_en  = ext_inst_en_q;
  assign level        = level_q;
  assign issued_count = issued_q;
  assign loop_count   = loop_q;
  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_mips_inst_injector.sv
// Directed bench for mips_inst_injector: load, one-shot, loop, abort, reset,
// full-buffer and clear cases with hand-computed expectations.
module tb_mips_inst_injector;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned LVL_W   = 5;

  localparam logic [STATE_W-1:0] FETCH = 4'd0;
  localparam logic [STATE_W-1:0] EXEC  = 4'd1;
  localparam logic [DATA_W-1:0]  NOP   = 32'h0000_0000;
  localparam logic [DATA_W-1:0]  W0    = 32'h2001_0005;
  localparam logic [DATA_W-1:0]  W1    = 32'h2002_0007;
  localparam logic [DATA_W-1:0]  W2    = 32'h0022_1820;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_valid;
  logic               wr_ready;
  logic [DATA_W-1:0]  wr_data;
  logic               clear;
  logic               start;
  logic               abort;
  logic               mode;
  logic [STATE_W-1:0] current_state;
  logic [DATA_W-1:0]  ext_inst;
  logic               ext_inst_en;
  logic [LVL_W-1:0]   level;
  logic [CNT_W-1:0]   issued_count;
  logic [CNT_W-1:0]   loop_count;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] loop_seq [7];
  logic [DATA_W-1:0] full_w   [DEPTH];

  mips_inst_injector dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .clear         (clear),
    .start         (start),
    .abort         (abort),
    .mode          (mode),
    .current_state (current_state),
    .ext_inst      (ext_inst),
    .ext_inst_en   (ext_inst_en),
    .level         (level),
    .issued_count  (issued_count),
    .loop_count    (loop_count),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One core fetch: sit in FETCH for an edge, then leave it.
  task automatic fetch();
    current_state = FETCH;
    step();
    current_state = EXEC;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    loop_seq = '{W0, W1, W2, W0, W1, W2, W0};
    for (int i = 0; i < DEPTH; i++) full_w[i] = 32'hA000_0100 + 32'(i);

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; clear = 1'b0;
    start = 1'b0; abort = 1'b0; mode = 1'b0; current_state = EXEC;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_ext_inst", ext_inst, NOP);
    check("rst_ext_en", ext_inst_en, 0);
    check("rst_level", level, 0);
    check("rst_issued", issued_count, 0);
    check("rst_loop", loop_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 1);

    // Load three words
    wr_valid = 1'b1;
    wr_data = W0; step();
    wr_data = W1; step();
    wr_data = W2; step();
    wr_valid = 1'b0;
    check("load3_level", level, 3);

    // One-shot run
    mode = 1'b0; start = 1'b1; step(); start = 1'b0;
    check("os_busy", busy, 1);
    check("os_en", ext_inst_en, 1);
    check("os_w0", ext_inst, W0);
    check("os_issued0", issued_count, 0);
    fetch();
    check("os_w1", ext_inst, W1);
    check("os_issued1", issued_count, 1);
    fetch();
    check("os_w2", ext_inst, W2);
    fetch();
    check("os_nop", ext_inst, NOP);
    check("os_done", done, 1);
    check("os_busy_end", busy, 0);
    check("os_en_end", ext_inst_en, 1);
    check("os_issued3", issued_count, 3);
    check("os_wr_ready_done", wr_ready, 0);

    // Loop run restarted from DONE
    mode = 1'b1; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("loop_seq%0d", i), ext_inst, loop_seq[i]);
      fetch();
    end
    check("loop_count2", loop_count, 2);
    check("loop_issued7", issued_count, 7);
    check("loop_busy", busy, 1);
    check("loop_next_w1", ext_inst, W1);

    // Abort coinciding with a consumption event
    current_state = FETCH; step();
    current_state = EXEC; abort = 1'b1; step(); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_en", ext_inst_en, 0);
    check("abort_ext", ext_inst, NOP);
    check("abort_issued", issued_count, 7);
    check("abort_level", level, 3);

    // Replay after abort
    mode = 1'b0; start = 1'b1; step(); start = 1'b0;
    check("replay_w0", ext_inst, W0);
    check("replay_en", ext_inst_en, 1);
    check("replay_issued0", issued_count, 0);
    fetch();
    check("replay_w1", ext_inst, W1);

    // Clear and writes ignored while running
    clear = 1'b1; wr_valid = 1'b1; wr_data = 32'h1111_1111; step();
    clear = 1'b0; wr_valid = 1'b0;
    check("run_clear_level", level, 3);
    check("run_clear_busy", busy, 1);
    check("run_wr_ready", wr_ready, 0);

    // Reset mid-run after two issues
    fetch();
    check("pre_rst_issued", issued_count, 2);
    check("pre_rst_w2", ext_inst, W2);
    current_state = FETCH; step();
    rst = 1'b1; current_state = EXEC; step(); rst = 1'b0;
    check("mid_rst_ext", ext_inst, NOP);
    check("mid_rst_en", ext_inst_en, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_issued", issued_count, 0);
    check("mid_rst_loop", loop_count, 0);
    check("mid_rst_busy", busy, 0);
    step();
    check("post_rst_issued", issued_count, 0);

    // Fill the buffer and offer one more word
    wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data = full_w[i];
      step();
    end
    check("full_level", level, 16);
    check("full_ready", wr_ready, 0);
    wr_data = 32'hDEAD_BEEF; step();
    check("full_level_hold", level, 16);
    check("full_ready_hold", wr_ready, 0);
    wr_valid = 1'b0;

    // Full program, one-shot: the extra word must never appear
    mode = 1'b0; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("full_w%0d", i), ext_inst, full_w[i]);
      fetch();
    end
    check("full_nop", ext_inst, NOP);
    check("full_done", done, 1);
    check("full_issued", issued_count, 16);

    // Clear from DONE
    clear = 1'b1; step(); clear = 1'b0;
    check("done_clear_level", level, 0);
    check("done_clear_done", done, 0);
    check("done_clear_ready", wr_ready, 1);
    check("done_clear_en", ext_inst_en, 0);

    // Start with an empty buffer
    start = 1'b1; step(); start = 1'b0;
    check("empty_start_busy", busy, 0);
    check("empty_start_en", ext_inst_en, 0);

    // Clear beats a same-cycle write in IDLE
    wr_valid = 1'b1; wr_data = W0; step(); wr_valid = 1'b0;
    check("idle_write_level", level, 1);
    wr_valid = 1'b1; clear = 1'b1; wr_data = W1; step();
    wr_valid = 1'b0; clear = 1'b0;
    check("idle_clear_level", level, 0);
    start = 1'b1; step(); start = 1'b0;
    check("idle_clear_start", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
